// File: rtl/srl_sra_multicycle.sv
// Iterative 32-bit logical/arithmetic right shifter: one power-of-two stage per clock (16, 8, 4, 2, 1).
// Optional macro SRL_SRA_EARLY_EXIT_EN visits only the stages whose shift-amount bit is set.
module srl_sra_multicycle (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [4:0]  shiftamt,
    input  logic        arith,
    output logic [31:0] out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S16  = 3'd1,
        ST_S8   = 3'd2,
        ST_S4   = 3'd3,
        ST_S2   = 3'd4,
        ST_S1   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [4:0]  amt_q, amt_d;
    logic        fill_q, fill_d;
    logic [31:0] out_q, out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [31:0] stage_res [5];
    logic [2:0]  cur_idx;
    logic [31:0] stepped;
    logic        last_stage;
    state_t      next_stage;

    // Candidate result of every stage; the active one is selected by cur_idx.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_stage
            localparam int K = 1 << gi;
            assign stage_res[gi] = {{K{fill_q}}, work_q[31:K]};
        end
    endgenerate

    function automatic state_t idx_to_state(input logic [2:0] idx);
        case (idx)
            3'd4:    return ST_S16;
            3'd3:    return ST_S8;
            3'd2:    return ST_S4;
            3'd1:    return ST_S2;
            default: return ST_S1;
        endcase
    endfunction

`ifdef SRL_SRA_EARLY_EXIT_EN
    // Highest set bit selects the first stage; zero amount lands on S1 as a pass-through.
    function automatic state_t first_stage(input logic [4:0] amt);
        if (amt[4])      return ST_S16;
        else if (amt[3]) return ST_S8;
        else if (amt[2]) return ST_S4;
        else if (amt[1]) return ST_S2;
        else             return ST_S1;
    endfunction
`endif

    always_comb begin
        case (state_q)
            ST_S16:  cur_idx = 3'd4;
            ST_S8:   cur_idx = 3'd3;
            ST_S4:   cur_idx = 3'd2;
            ST_S2:   cur_idx = 3'd1;
            default: cur_idx = 3'd0;
        endcase
    end

    assign stepped = amt_q[cur_idx] ? stage_res[cur_idx] : work_q;

`ifdef SRL_SRA_EARLY_EXIT_EN
    logic [4:0] lower_bits;
    assign lower_bits = amt_q & ((5'd1 << cur_idx) - 5'd1);
    assign last_stage = (lower_bits == 5'd0);
    assign next_stage = first_stage(lower_bits);
`else
    assign last_stage = (state_q == ST_S1);
    assign next_stage = idx_to_state(cur_idx - 3'd1);
`endif

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        amt_d   = amt_q;
        fill_d  = fill_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (start) begin
                work_d  = A;
                amt_d   = shiftamt;
                fill_d  = arith & A[31];
                busy_d  = 1'b1;
`ifdef SRL_SRA_EARLY_EXIT_EN
                state_d = first_stage(shiftamt);
`else
                state_d = ST_S16;
`endif
            end
        end else begin
            work_d = stepped;
            if (last_stage) begin
                out_d   = stepped;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end else begin
                state_d = next_stage;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            work_q  <= 32'd0;
            amt_q   <= 5'd0;
            fill_q  <= 1'b0;
            out_q   <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            amt_q   <= amt_d;
            fill_q  <= fill_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
